// File: rtl/avr_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : avr_tx_arbiter
//  Description : Message-granular round-robin arbiter sharing one AVR
//                USB-serial TX channel among NUM_REQ byte sources, with
//                tx_busy pacing and timeout reclaim of stalled owners.
//  Revision    : 1.0 - initial release
// ============================================================================
module avr_tx_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ-1:0]     i_byte_valid,
    input  logic [8*NUM_REQ-1:0]   i_byte_data,
    input  logic [NUM_REQ-1:0]     i_byte_last,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [NUM_REQ-1:0]     o_byte_ack,
    output logic [NUM_REQ-1:0]     o_abort,
    input  logic                   i_tx_busy,
    output logic [7:0]             o_tx_data,
    output logic                   o_new_tx_data
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [PTR_W-1:0]   C_PTR_MAX  = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W-1:0]   C_PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);
    localparam logic [NUM_REQ-1:0] C_ONE      = NUM_REQ'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] w_ack_nxt;
    logic [NUM_REQ-1:0] r_abort;
    logic [NUM_REQ-1:0] w_abort_nxt;
    logic [7:0]         r_tx_data;
    logic [7:0]         w_tx_data_nxt;
    logic               r_new;
    logic               w_new_nxt;

    logic [7:0]         w_lane [NUM_REQ];
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_sel;
    logic               w_found;
    logic               w_own_req;
    logic               w_send;
    logic               w_expire;
    logic [NUM_REQ-1:0] w_own_oh;
    logic [NUM_REQ-1:0] w_sel_oh;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign w_lane[gi] = i_byte_data[8*gi +: 8];
        end
    endgenerate

    // Rotating scan starting just after the last owner, so it ranks lowest.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (w_idx == C_PTR_MAX) ? '0 : w_idx + C_PTR_ONE;
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // The pointer always names the current owner while a grant is held.
    assign w_own_req = i_req[r_ptr];
    assign w_send    = i_byte_valid[r_ptr] && !i_tx_busy;
    assign w_expire  = (r_cnt == C_CNT_LAST);
    assign w_own_oh  = C_ONE << r_ptr;
    assign w_sel_oh  = C_ONE << w_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= C_PTR_MAX;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_ack     <= '0;
            r_abort   <= '0;
            r_tx_data <= 8'h00;
            r_new     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_grant   <= w_grant_nxt;
            r_ack     <= w_ack_nxt;
            r_abort   <= w_abort_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_new     <= w_new_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!w_own_req) begin
                    w_state_nxt = S_IDLE;
                end else if (w_send) begin
                    w_state_nxt = i_byte_last[r_ptr] ? S_IDLE : S_HOLD;
                end else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_ACTIVE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_grant_nxt   = r_grant;
        w_ack_nxt     = '0;
        w_abort_nxt   = '0;
        w_tx_data_nxt = r_tx_data;
        w_new_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_nxt = '0;
                if (w_found) begin
                    w_grant_nxt = w_sel_oh;
                    w_ptr_nxt   = w_sel;
                    w_cnt_nxt   = '0;
                end
            end
            S_ACTIVE: begin
                if (!w_own_req) begin
                    w_grant_nxt = '0;
                end else if (w_send) begin
                    w_tx_data_nxt = w_lane[r_ptr];
                    w_new_nxt     = 1'b1;
                    w_ack_nxt     = w_own_oh;
                    w_cnt_nxt     = '0;
                    if (i_byte_last[r_ptr]) begin
                        w_grant_nxt = '0;
                    end
                end else if (w_expire) begin
                    w_grant_nxt = '0;
                    w_abort_nxt = w_own_oh;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_HOLD: begin
            end
            default: begin
                w_grant_nxt = '0;
            end
        endcase
    end

    assign o_grant       = r_grant;
    assign o_byte_ack    = r_ack;
    assign o_abort       = r_abort;
    assign o_tx_data     = r_tx_data;
    assign o_new_tx_data = r_new;

endmodule
`default_nettype wire

// File: tb/tb_avr_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avr_tx_arbiter
//  Description : Self-checking bench: cycle vector table plus source models
//                feeding a byte scoreboard for arbitration corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avr_tx_arbiter;

    localparam int NR = 3;
    localparam int TO = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] i_req, i_byte_valid, i_byte_last;
    logic [8*NR-1:0] i_byte_data;
    logic          i_tx_busy;
    logic [NR-1:0] o_grant, o_byte_ack, o_abort;
    logic [7:0]    o_tx_data;
    logic          o_new_tx_data;

    always #5 clk = ~clk;

    avr_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data),
        .i_byte_last(i_byte_last),
        .o_grant(o_grant), .o_byte_ack(o_byte_ack), .o_abort(o_abort),
        .i_tx_busy(i_tx_busy), .o_tx_data(o_tx_data), .o_new_tx_data(o_new_tx_data)
    );

    typedef struct packed {
        logic [2:0]  req;
        logic [2:0]  valid;
        logic [2:0]  last;
        logic [23:0] data;
        logic        busy;
        logic [17:0] exp;   // {grant, ack, abort, new, tx_data}
    } vec_t;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] data;
    } sb_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   viol  = 0;
    int   n_new = 0;
    logic [NR-1:0] p_ack = '0, p_abort = '0;
    logic          p_new = 1'b0;
    logic [NR-1:0] en  = '1;
    logic [NR-1:0] ven = '1;
    logic [8:0]    src_q [NR][$];
    sb_t           sb [$];
    vec_t          tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [2:0] req, logic [2:0] valid, logic [2:0] last,
                                logic [23:0] data, logic busy, logic [17:0] exp);
        vec_t v;
        v.req = req; v.valid = valid; v.last = last; v.data = data; v.busy = busy; v.exp = exp;
        return v;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            i_req[i]            = en[i] && (src_q[i].size() != 0);
            i_byte_valid[i]     = i_req[i] && ven[i];
            i_byte_last[i]      = (src_q[i].size() != 0) ? src_q[i][0][8] : 1'b0;
            i_byte_data[8*i +: 8] = (src_q[i].size() != 0) ? src_q[i][0][7:0] : 8'h00;
        end
    endtask

    task automatic load(input int s, input logic last, input logic [7:0] b, input bit expect_out);
        src_q[s].push_back({last, b});
        if (expect_out) sb.push_back({2'(s), b});
    endtask

    // One clock: observe outputs, score sent bytes, then let sources react.
    task automatic tick();
        sb_t e;
        @(posedge clk); #1;
        if ($countones(o_grant) > 1 || $countones(o_byte_ack) > 1 || $countones(o_abort) > 1) viol++;
        if ((o_byte_ack & p_ack) != 0 || (o_abort & p_abort) != 0 || (o_new_tx_data && p_new)) viol++;
        if (o_byte_ack != 0 && !o_new_tx_data) viol++;
        p_ack = o_byte_ack; p_abort = o_abort; p_new = o_new_tx_data;
        if (o_new_tx_data) begin
            n_new++;
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_extra: got byte %0h on ack %0b, expected no byte", o_tx_data, o_byte_ack);
            end else begin
                e = sb.pop_front();
                chk("sb_byte", {o_byte_ack, o_tx_data}, {3'b001 << e.lane, e.data});
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (o_byte_ack[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            if (o_abort[i]) src_q[i].delete();
        end
        drive();
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 300; k++) begin
            if (sb.size() == 0 && all_empty() && o_grant == '0) break;
            tick();
        end
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        int c, s;
        // Message "AB\n" on lane 0, then a busy-stalled single byte on lane 2.
        tbl[0]  = mk(3'b000, 3'b000, 3'b000, 24'h000000, 1'b0, {3'b000, 3'b000, 3'b000, 1'b0, 8'h00});
        tbl[1]  = mk(3'b001, 3'b001, 3'b000, 24'h000041, 1'b0, {3'b001, 3'b000, 3'b000, 1'b0, 8'h00});
        tbl[2]  = mk(3'b001, 3'b001, 3'b000, 24'h000041, 1'b0, {3'b001, 3'b001, 3'b000, 1'b1, 8'h41});
        tbl[3]  = mk(3'b001, 3'b001, 3'b000, 24'h000042, 1'b0, {3'b001, 3'b000, 3'b000, 1'b0, 8'h41});
        tbl[4]  = mk(3'b001, 3'b001, 3'b000, 24'h000042, 1'b0, {3'b001, 3'b001, 3'b000, 1'b1, 8'h42});
        tbl[5]  = mk(3'b001, 3'b001, 3'b001, 24'h00000A, 1'b0, {3'b001, 3'b000, 3'b000, 1'b0, 8'h42});
        tbl[6]  = mk(3'b001, 3'b001, 3'b001, 24'h00000A, 1'b0, {3'b000, 3'b001, 3'b000, 1'b1, 8'h0A});
        tbl[7]  = mk(3'b000, 3'b000, 3'b000, 24'h000000, 1'b0, {3'b000, 3'b000, 3'b000, 1'b0, 8'h0A});
        tbl[8]  = mk(3'b100, 3'b100, 3'b100, 24'h550000, 1'b1, {3'b100, 3'b000, 3'b000, 1'b0, 8'h0A});
        tbl[9]  = mk(3'b100, 3'b100, 3'b100, 24'h550000, 1'b1, {3'b100, 3'b000, 3'b000, 1'b0, 8'h0A});
        tbl[10] = mk(3'b100, 3'b100, 3'b100, 24'h550000, 1'b0, {3'b000, 3'b100, 3'b000, 1'b1, 8'h55});
        tbl[11] = mk(3'b000, 3'b000, 3'b000, 24'h000000, 1'b0, {3'b000, 3'b000, 3'b000, 1'b0, 8'h55});

        rst = 1'b1; i_req = '0; i_byte_valid = '0; i_byte_last = '0; i_byte_data = '0; i_tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {o_grant, o_byte_ack, o_abort, o_new_tx_data, o_tx_data}, 0);
        rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            i_req = tbl[v].req; i_byte_valid = tbl[v].valid; i_byte_last = tbl[v].last;
            i_byte_data = tbl[v].data; i_tx_busy = tbl[v].busy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", v), {o_grant, o_byte_ack, o_abort, o_new_tx_data, o_tx_data}, tbl[v].exp);
        end

        // Round-robin among three held requests, 1-byte messages.
        load(0, 1'b1, 8'h10, 1); load(1, 1'b1, 8'h20, 1); load(2, 1'b1, 8'h30, 1); load(0, 1'b1, 8'h11, 0);
        sb.push_back({2'd0, 8'h11});
        drive();
        drain("rr_drain");

        // Source 1 requests while 0 owns a 3-byte message: 1 goes before 0's next message.
        load(0, 1'b0, 8'hA0, 1); load(0, 1'b0, 8'hA1, 1); load(0, 1'b1, 8'hA2, 1); load(0, 1'b1, 8'hA3, 0);
        drive();
        repeat (3) tick();
        chk("rr_owner", o_grant, 3'b001);
        load(1, 1'b1, 8'h21, 1);
        sb.push_back({2'd0, 8'hA3});
        drive();
        drain("rr2_drain");

        // Backpressure for 20 cycles mid-message.
        load(2, 1'b0, 8'hB0, 1); load(2, 1'b0, 8'hB1, 1); load(2, 1'b1, 8'hB2, 1);
        drive();
        for (int k = 0; k < 20 && !o_new_tx_data; k++) tick();
        chk("bp_first", o_new_tx_data, 1);
        i_tx_busy = 1'b1;
        s = n_new;
        repeat (20) tick();
        chk("bp_nosend", n_new - s, 0);
        chk("bp_grant", o_grant, 3'b100);
        i_tx_busy = 1'b0;
        tick();
        chk("bp_resume", o_new_tx_data, 1);
        drain("bp_drain");

        // Timeout: owner holds req without presenting a byte.
        ven[1] = 1'b0;
        load(1, 1'b1, 8'h77, 0);
        drive();
        for (int k = 0; k < 10 && o_grant != 3'b010; k++) tick();
        chk("to_grant", o_grant, 3'b010);
        load(2, 1'b1, 8'h66, 1);
        drive();
        c = 0;
        for (int k = 0; k < 100 && o_abort == '0; k++) begin tick(); c++; end
        chk("to_cycles", c, TO);
        chk("to_abort", o_abort, 3'b010);
        chk("to_grant_off", o_grant, 3'b000);
        tick();
        chk("to_next", o_grant, 3'b100);
        ven[1] = 1'b1;
        drain("to_drain");

        // tx_busy stuck high: timeout with zero sends.
        i_tx_busy = 1'b1;
        load(0, 1'b0, 8'hC0, 0); load(0, 1'b1, 8'hC1, 0);
        drive();
        for (int k = 0; k < 10 && o_grant != 3'b001; k++) tick();
        chk("stuck_grant", o_grant, 3'b001);
        s = n_new;
        c = 0;
        for (int k = 0; k < 100 && o_abort == '0; k++) begin tick(); c++; end
        chk("stuck_cycles", c, TO);
        chk("stuck_abort", o_abort, 3'b001);
        chk("stuck_sends", n_new - s, 0);
        i_tx_busy = 1'b0;
        tick();

        // Voluntary withdrawal while ACTIVE.
        load(0, 1'b0, 8'hD0, 1); load(0, 1'b0, 8'hD1, 0); load(0, 1'b1, 8'hD2, 0);
        drive();
        for (int k = 0; k < 10 && !o_new_tx_data; k++) tick();
        chk("wd_first", o_new_tx_data, 1);
        i_tx_busy = 1'b1;
        tick(); tick();
        en[0] = 1'b0;
        drive();
        tick();
        chk("wd_grant", o_grant, 3'b000);
        chk("wd_abort", o_abort, 3'b000);
        src_q[0].delete(); en[0] = 1'b1; i_tx_busy = 1'b0;
        drive();
        tick();

        // Reset during HOLD, then req[0] wins the first scan.
        load(1, 1'b0, 8'hE0, 1); load(1, 1'b0, 8'hE1, 0); load(1, 1'b1, 8'hE2, 0);
        drive();
        for (int k = 0; k < 10 && !o_new_tx_data; k++) tick();
        chk("rst_pre", o_new_tx_data, 1);
        rst = 1'b1;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        drive();
        tick();
        chk("rst_mid", {o_grant, o_byte_ack, o_abort, o_new_tx_data, o_tx_data}, 0);
        rst = 1'b0;
        load(0, 1'b1, 8'hF0, 1); load(2, 1'b1, 8'hF2, 1);
        drive();
        tick();
        chk("rst_first", o_grant, 3'b001);
        drain("rst_drain");

        chk("protocol", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
